// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register for the RV32 core.
// Carries a control field and a data field between two stages, with
// back-pressure, flush and a 1-cycle accept-to-output latency.
// Optional feature macro: PIPE_STAGE_REG_SKID_EN
//   defined   -> 2-entry (main + skid) stage, ready_o is a pure register output
//   undefined -> single entry, ready_o = ready_i | ~valid_o (combinational)
// Reset is synchronous, active-low (rst_ni).
module pipe_stage_reg #(
  parameter int DATA_W         = 96,
  parameter int CTRL_W         = 16,
  parameter bit FLUSH_CLR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o
);

  // Main entry: this is what the downstream stage sees.
  logic              main_valid_reg, main_valid_next;
  logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg,  main_data_next;

  logic accept;
  logic issue;

  assign issue = main_valid_reg & ready_i;

`ifdef PIPE_STAGE_REG_SKID_EN
  // Skid entry: catches the one entry accepted while main is stalled, so
  // ready_o can be a register and still not lose anything.
  logic              skid_valid_reg, skid_valid_next;
  logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg,  skid_data_next;

  // ready_o depends only on state, never on ready_i.
  assign ready_o = ~skid_valid_reg;
  assign accept  = valid_i & ready_o;

  // Next-state for main and skid entries; flush overrides normal movement.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_ctrl_next  = main_ctrl_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    skid_data_next  = skid_data_reg;

    if (skid_valid_reg) begin
      // ready_o is low here, so no accept can compete with the refill.
      if (issue) begin
        main_valid_next = 1'b1;
        main_ctrl_next  = skid_ctrl_reg;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
        skid_ctrl_next  = '0;
      end
    end else if (accept) begin
      if (!main_valid_reg || issue) begin
        main_valid_next = 1'b1;
        main_ctrl_next  = ctrl_i;
        main_data_next  = data_i;
      end else begin
        // Main is stalled: park the new entry in the skid register.
        skid_valid_next = 1'b1;
        skid_ctrl_next  = ctrl_i;
        skid_data_next  = data_i;
      end
    end else if (issue) begin
      // Bubble: clear ctrl so no stale reg_write/mem_write leaks downstream.
      main_valid_next = 1'b0;
      main_ctrl_next  = '0;
    end

    if (flush_i) begin
      main_valid_next = 1'b0;
      main_ctrl_next  = '0;
      skid_valid_next = 1'b0;
      skid_ctrl_next  = '0;
      if (FLUSH_CLR_DATA) begin
        main_data_next = '0;
      end
    end
  end

  // Skid entry register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= '0;
      skid_data_reg  <= '0;
    end else begin
      skid_valid_reg <= skid_valid_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      skid_data_reg  <= skid_data_next;
    end
  end

  assign occupancy_o = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};
`else
  // Single-entry stage: can take a new entry when empty or when draining.
  assign ready_o = ready_i | ~main_valid_reg;
  assign accept  = valid_i & ready_o;

  // Next-state for the single entry; flush overrides normal movement.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_ctrl_next  = main_ctrl_reg;
    main_data_next  = main_data_reg;

    if (accept) begin
      main_valid_next = 1'b1;
      main_ctrl_next  = ctrl_i;
      main_data_next  = data_i;
    end else if (issue) begin
      // Bubble: clear ctrl so no stale reg_write/mem_write leaks downstream.
      main_valid_next = 1'b0;
      main_ctrl_next  = '0;
    end

    if (flush_i) begin
      main_valid_next = 1'b0;
      main_ctrl_next  = '0;
      if (FLUSH_CLR_DATA) begin
        main_data_next = '0;
      end
    end
  end

  assign occupancy_o = {1'b0, main_valid_reg};
`endif

  // Main entry register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_valid_reg <= 1'b0;
      main_ctrl_reg  <= '0;
      main_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_ctrl_reg  <= main_ctrl_next;
      main_data_reg  <= main_data_next;
    end
  end

  assign valid_o = main_valid_reg;
  // Control is only meaningful alongside a valid entry.
  assign ctrl_o  = main_ctrl_reg & {CTRL_W{main_valid_reg}};
  assign data_o  = main_data_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed, table-driven bench for pipe_stage_reg.
// Expectations follow the build selected by PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, valid_in, rdy_in;
  logic [15:0] ctrl_in;
  logic [95:0] data_in;

  logic        ready_a, valid_a;
  logic [15:0] ctrl_a;
  logic [95:0] data_a;
  logic [1:0]  occ_a;

  logic        ready_b, valid_b;
  logic [15:0] ctrl_b;
  logic [95:0] data_b;
  logic [1:0]  occ_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .FLUSH_CLR_DATA(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_a),
    .ctrl_i(ctrl_in), .data_i(data_in), .valid_o(valid_a), .ready_i(rdy_in),
    .ctrl_o(ctrl_a), .data_o(data_a), .occupancy_o(occ_a)
  );

  // Same stimulus, but data must survive a flush.
  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .FLUSH_CLR_DATA(1'b0)) dut_hold (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_b),
    .ctrl_i(ctrl_in), .data_i(data_in), .valid_o(valid_b), .ready_i(rdy_in),
    .ctrl_o(ctrl_b), .data_o(data_b), .occupancy_o(occ_b)
  );

  typedef struct {
    logic        rst_n, flush, valid, rdy;
    logic [15:0] ctrl;
    logic [95:0] data;
    logic        ev;
    logic [15:0] ec;
    logic [95:0] ed;
    logic [1:0]  eo;
    logic        er;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic r, f, v, rd, input logic [15:0] c, input logic [95:0] d,
                              input logic ev, input logic [15:0] ec, input logic [95:0] ed,
                              input logic [1:0] eo, input logic er);
    vec_t t;
    t.rst_n = r; t.flush = f; t.valid = v; t.rdy = rd; t.ctrl = c; t.data = d;
    t.ev = ev; t.ec = ec; t.ed = ed; t.eo = eo; t.er = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, f, v, rd, input logic [15:0] c, input logic [95:0] d);
    rst_n = r; flush = f; valid_in = v; rdy_in = rd; ctrl_in = c; data_in = d;
  endtask

  initial begin
    int sent, got;
    logic acc, iss;

    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 96'hAA);

    // Reset, streaming, bubble and single-entry stall vectors.
    tbl[0] = mk(0, 0, 1, 1, 16'hFFFF, 96'hAA, 0, 16'h0, 96'h0, 2'd0, 1);
    tbl[1] = mk(0, 0, 1, 1, 16'hFFFF, 96'hAA, 0, 16'h0, 96'h0, 2'd0, 1);
    for (int k = 1; k <= 8; k++)
      tbl[1+k] = mk(1, 0, 1, 1, 16'(16'h10 + k), 96'(k), 1, 16'(16'h10 + k), 96'(k), 2'd1, 1);
    tbl[10] = mk(1, 0, 0, 1, 16'h0,    96'h0,  0, 16'h0,    96'h8,  2'd0, 1);
    tbl[11] = mk(1, 0, 1, 1, 16'h0001, 96'h55, 1, 16'h0001, 96'h55, 2'd1, 1);
    tbl[12] = mk(1, 0, 0, 1, 16'h0,    96'h0,  0, 16'h0,    96'h55, 2'd0, 1);
    tbl[13] = mk(1, 0, 0, 0, 16'h0,    96'h0,  0, 16'h0,    96'h55, 2'd0, 1);
    tbl[14] = mk(1, 0, 1, 0, 16'h0022, 96'h66, 1, 16'h0022, 96'h66, 2'd1, SKID);
    tbl[15] = mk(1, 0, 0, 0, 16'h0,    96'h0,  1, 16'h0022, 96'h66, 2'd1, SKID);
    tbl[16] = mk(1, 0, 0, 1, 16'h0,    96'h0,  0, 16'h0,    96'h66, 2'd0, 1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst_n, tbl[i].flush, tbl[i].valid, tbl[i].rdy, tbl[i].ctrl, tbl[i].data);
      tick();
      check($sformatf("vec%0d_valid", i), 128'(valid_a), 128'(tbl[i].ev));
      check($sformatf("vec%0d_ctrl", i),  128'(ctrl_a),  128'(tbl[i].ec));
      check($sformatf("vec%0d_data", i),  128'(data_a),  128'(tbl[i].ed));
      check($sformatf("vec%0d_occ", i),   128'(occ_a),   128'(tbl[i].eo));
      check($sformatf("vec%0d_ready", i), 128'(ready_a), 128'(tbl[i].er));
      $display("vec %0d: valid=%0b ctrl=%0h data=%0h occ=%0d ready=%0b",
               i, valid_a, ctrl_a, data_a, occ_a, ready_a);
    end

    // Back-pressure: 8 entries with a 1-cycle downstream stall at cycle 2.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      drive(1'b1, 1'b0, sent < 8, cyc != 2, 16'(16'h40 + sent), 96'(96'h101 + sent));
      #1;
      if (cyc == 2) check("bp_ready_in_stall", 128'(ready_a), 128'(SKID));
      if (cyc == 3) check("bp_ready_after_stall", 128'(ready_a), 128'(!SKID));
      acc = valid_in & ready_a;
      iss = valid_a & rdy_in;
      if (iss) begin
        check($sformatf("bp_data%0d", got), 128'(data_a), 128'(96'h101 + got));
        check($sformatf("bp_ctrl%0d", got), 128'(ctrl_a), 128'(16'h40 + got));
        $display("bp cycle %0d: issued data=%0h", cyc, data_a);
        got++;
      end
      tick();
      if (acc) sent++;
      if (cyc == 2) check("bp_occ_after_stall", 128'(occ_a), SKID ? 128'd2 : 128'd1);
    end
    check("bp_all_issued", 128'(got), 128'd8);
    check("bp_drained_valid", 128'(valid_a), 128'd0);

    // Flush with a full stage and a new entry offered in the flush cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h51, 96'h201);
    tick();
    check("fl_occ1", 128'(occ_a), 128'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h52, 96'h202);
    tick();
    check("fl_occ_full", 128'(occ_a), SKID ? 128'd2 : 128'd1);
    check("fl_ready_full", 128'(ready_a), 128'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h53, 96'h203);
    tick();
    check("fl_valid", 128'(valid_a), 128'd0);
    check("fl_ctrl", 128'(ctrl_a), 128'd0);
    check("fl_data_clr", 128'(data_a), 128'd0);
    check("fl_occ", 128'(occ_a), 128'd0);
    check("fl_data_hold", 128'(data_b), 128'h201);
    check("fl_hold_ctrl", 128'(ctrl_b), 128'd0);
    $display("flush: valid=%0b ctrl=%0h data=%0h held=%0h occ=%0d", valid_a, ctrl_a, data_a, data_b, occ_a);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 96'h0);
    tick();
    check("fl_no_leak_valid", 128'(valid_a), 128'd0);
    check("fl_no_leak_occ", 128'(occ_a), 128'd0);
    check("fl_hold_valid", 128'(valid_b), 128'd0);

    // Reset while stalled and full; reset must win over a simultaneous flush.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h61, 96'h301);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h62, 96'h302);
    tick();
    check("rs_occ_full", 128'(occ_a), SKID ? 128'd2 : 128'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h63, 96'h303);
    tick();
    check("rs_valid", 128'(valid_a), 128'd0);
    check("rs_ctrl", 128'(ctrl_a), 128'd0);
    check("rs_data", 128'(data_a), 128'd0);
    check("rs_occ", 128'(occ_a), 128'd0);
    check("rs_hold_data", 128'(data_b), 128'd0);
    $display("reset mid-stall: valid=%0b ctrl=%0h data=%0h occ=%0d", valid_a, ctrl_a, data_a, occ_a);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 96'h0);
    tick();
    check("rs_after_valid", 128'(valid_a), 128'd0);
    check("rs_after_ready", 128'(ready_a), 128'd1);
    check("rs_after_occ", 128'(occ_a), 128'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h64, 96'h304);
    tick();
    check("rs_new_valid", 128'(valid_a), 128'd1);
    check("rs_new_data", 128'(data_a), 128'h304);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 96'h0);
    tick();
    check("rs_new_drained", 128'(valid_a), 128'd0);
    check("rs_new_occ", 128'(occ_a), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
